// File: rtl/ask4_symbol_slicer.sv
// ask4_symbol_slicer
// Receive-side 4-ASK decision block. It sits after the matched filter and runs
// on the sample/symbol strobes. Once per symbol it captures one sample at a
// selectable phase and slices it against +/-ref_level and 0 to give a 2-bit
// symbol. ref_level tracks the mean magnitude of the captured samples over
// blocks of 2^AVG_LOG2 symbols.
//
// Ports
//   sys_clk     system clock, all state on rising edge
//   reset       asynchronous reset, active low
//   sam_clk_en  sample strobe (one cycle wide)
//   sym_clk_en  symbol strobe, only meaningful together with sam_clk_en
//   y_in        signed matched-filter sample
//   phase_sel   sample phase (0-3) used for the decision, applied per symbol
//   sym_out     decision: 00=-3, 01=-1, 10=+1, 11=+3
//   sym_valid   one-cycle pulse when sym_out updates
//   ref_level   magnitude threshold estimate (MSB always 0)
//   locked      set once the first estimation block has completed
module ask4_symbol_slicer #(
    parameter int WIDTH    = 18,
    parameter int AVG_LOG2 = 10,
    parameter int REF_INIT = 65536
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    sam_clk_en,
    input  logic                    sym_clk_en,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic [1:0]              phase_sel,
    output logic [1:0]              sym_out,
    output logic                    sym_valid,
    output logic [WIDTH-1:0]        ref_level,
    output logic                    locked
);

    localparam int ACC_W = WIDTH + AVG_LOG2;

    logic [1:0]              ph_q;
    logic [1:0]              ph_now;
    logic [1:0]              ph_sel_q;
    logic signed [WIDTH-1:0] samp_q;
    logic                    cap_q;
    logic [WIDTH-1:0]        mag;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_sum;
    logic [AVG_LOG2-1:0]     cnt;
    logic signed [WIDTH:0]   y_ext;
    logic signed [WIDTH:0]   r_pos;
    logic signed [WIDTH:0]   r_neg;
    logic [1:0]              slice;

    // Phase index of the sample present this cycle (only used on sam_clk_en).
    always_comb begin
        ph_now = sym_clk_en ? 2'd0 : ph_q + 2'd1;
    end

    // Magnitude; the most negative code has no positive twin, so clamp it.
    always_comb begin
        mag = samp_q;
        if (samp_q == {1'b1, {(WIDTH-1){1'b0}}})
            mag = {1'b0, {(WIDTH-1){1'b1}}};
        else if (samp_q[WIDTH-1])
            mag = WIDTH'(-samp_q);
    end

    // Include the current magnitude so the wrap cycle sees the full block.
    always_comb begin
        acc_sum = acc + ACC_W'(mag);
    end

    // One extra bit keeps -ref_level representable against the sample.
    always_comb begin
        y_ext = {samp_q[WIDTH-1], samp_q};
        r_pos = {1'b0, ref_level};
        r_neg = -r_pos;
        if (y_ext < r_neg)
            slice = 2'b00;
        else if (y_ext[WIDTH])
            slice = 2'b01;
        else if (y_ext < r_pos)
            slice = 2'b10;
        else
            slice = 2'b11;
    end

    // Phase tracking and capture.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            ph_q     <= 2'd0;
            ph_sel_q <= 2'd0;
            samp_q   <= '0;
            cap_q    <= 1'b0;
        end else begin
            cap_q <= 1'b0;
            if (sam_clk_en) begin
                ph_q <= ph_now;
                // Compare against the selection held for this symbol; the new
                // phase_sel only applies from the next symbol.
                if (ph_now == ph_sel_q) begin
                    samp_q <= y_in;
                    cap_q  <= 1'b1;
                end
                if (sym_clk_en)
                    ph_sel_q <= phase_sel;
            end
        end
    end

    // Decision and reference estimation.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sym_out   <= 2'b00;
            sym_valid <= 1'b0;
            ref_level <= WIDTH'(REF_INIT);
            locked    <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            sym_valid <= cap_q;
            if (cap_q) begin
                sym_out <= slice;
                cnt     <= cnt + AVG_LOG2'(1);
                if (cnt == {AVG_LOG2{1'b1}}) begin
                    ref_level <= acc_sum[ACC_W-1:AVG_LOG2];
                    acc       <= '0;
                    locked    <= 1'b1;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_ask4_symbol_slicer.sv
// Directed bench for ask4_symbol_slicer (AVG_LOG2=4 so blocks are 16 symbols).
module tb_ask4_symbol_slicer;

    localparam int W = 18;

    logic                sys_clk = 1'b0;
    logic                reset = 1'b0;
    logic                sam = 1'b0;
    logic                sym = 1'b0;
    logic signed [W-1:0] y = '0;
    logic [1:0]          psel = 2'd0;
    logic [1:0]          sym_out;
    logic                sym_valid;
    logic [W-1:0]        ref_level;
    logic                locked;

    int n_vec = 0;
    int n_err = 0;

    ask4_symbol_slicer #(.WIDTH(W), .AVG_LOG2(4), .REF_INIT(65536)) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam),
        .sym_clk_en (sym),
        .y_in       (y),
        .phase_sel  (psel),
        .sym_out    (sym_out),
        .sym_valid  (sym_valid),
        .ref_level  (ref_level),
        .locked     (locked)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int         y0;
        int         yo;
        logic [1:0] exp;
        string      name;
    } vec_t;

    vec_t       tbl[8];
    int         est_y[4];
    logic [1:0] est_e[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One sample: drive on a falling edge, then check sym_valid on the next
    // three falling edges (pulse expected only after E+1 when captured).
    task automatic samp(input int yv, input logic s, input logic [1:0] sel,
                        input logic cap, input logic [1:0] exp, input string name);
        @(negedge sys_clk);
        sam = 1'b1; sym = s; y = W'(yv); psel = sel;
        @(negedge sys_clk);
        sam = 1'b0; sym = 1'b0;
        chk({name, " valid@E"}, 32'(sym_valid), 32'd0);
        @(negedge sys_clk);
        chk({name, " valid@E+1"}, 32'(sym_valid), 32'(cap));
        if (cap) chk({name, " sym_out"}, 32'(sym_out), 32'(exp));
        @(negedge sys_clk);
        chk({name, " valid@E+2"}, 32'(sym_valid), 32'd0);
    endtask

    // Full symbol with phase_sel=0: phase 0 carries y0, the rest carry yo.
    task automatic sym4(input int y0, input int yo, input logic [1:0] exp, input string name);
        samp(y0, 1'b1, 2'd0, 1'b1, exp, name);
        samp(yo, 1'b0, 2'd0, 1'b0, 2'd0, name);
        samp(yo, 1'b0, 2'd0, 1'b0, 2'd0, name);
        samp(yo, 1'b0, 2'd0, 1'b0, 2'd0, name);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        reset = 1'b0; sam = 1'b0; sym = 1'b0; psel = 2'd0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b1;
    endtask

    initial begin
        tbl[0] = '{98303,   -131072, 2'b11, "const 98303 a"};
        tbl[1] = '{98303,   -131072, 2'b11, "const 98303 b"};
        tbl[2] = '{-65536,  131071,  2'b01, "bound -R"};
        tbl[3] = '{0,       -131072, 2'b10, "bound 0"};
        tbl[4] = '{65536,   -131072, 2'b11, "bound +R"};
        tbl[5] = '{-65537,  131071,  2'b00, "bound -R-1"};
        tbl[6] = '{65535,   -131072, 2'b10, "bound R-1"};
        tbl[7] = '{-1,      131071,  2'b01, "bound -1"};
        est_y = '{32768, -32768, 98303, -98303};
        est_e = '{2'b10, 2'b01, 2'b11, 2'b00};

        // Reset state.
        repeat (3) @(negedge sys_clk);
        chk("rst sym_out", 32'(sym_out), 32'd0);
        chk("rst sym_valid", 32'(sym_valid), 32'd0);
        chk("rst ref_level", 32'(ref_level), 32'd65536);
        chk("rst locked", 32'(locked), 32'd0);
        reset = 1'b1;

        // Table: constant level and slicer boundaries against R=65536.
        for (int i = 0; i < 8; i++)
            sym4(tbl[i].y0, tbl[i].yo, tbl[i].exp, tbl[i].name);
        chk("table ref_level", 32'(ref_level), 32'd65536);
        chk("table locked", 32'(locked), 32'd0);

        // Phase select. First symbol still captures phase 0 (held select was 0).
        do_reset();
        samp(90000,  1'b1, 2'd2, 1'b1, 2'b11, "phA0 old sel");
        samp(90000,  1'b0, 2'd2, 1'b0, 2'b00, "phA1");
        samp(-40000, 1'b0, 2'd2, 1'b1, 2'b01, "phA2");
        samp(90000,  1'b0, 2'd2, 1'b0, 2'b00, "phA3");
        samp(90000,  1'b1, 2'd2, 1'b0, 2'b00, "phB0");
        samp(90000,  1'b0, 2'd2, 1'b0, 2'b00, "phB1");
        samp(-40000, 1'b0, 2'd2, 1'b1, 2'b01, "phB2");
        samp(90000,  1'b0, 2'd2, 1'b0, 2'b00, "phB3");
        samp(90000,  1'b1, 2'd2, 1'b0, 2'b00, "phC0");
        samp(90000,  1'b0, 2'd1, 1'b0, 2'b00, "phC1 midsym change");
        samp(-40000, 1'b0, 2'd1, 1'b1, 2'b01, "phC2 held sel");
        samp(90000,  1'b0, 2'd1, 1'b0, 2'b00, "phC3");
        samp(90000,  1'b1, 2'd1, 1'b0, 2'b00, "phD0");
        samp(131071, 1'b0, 2'd1, 1'b1, 2'b11, "phD1 new sel");
        samp(-40000, 1'b0, 2'd1, 1'b0, 2'b00, "phD2");
        samp(90000,  1'b0, 2'd1, 1'b0, 2'b00, "phD3");

        // Estimator block; all decisions use the initial threshold.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            sym4(est_y[i % 4], 0, est_e[i % 4], $sformatf("est sym%0d", i));
            if (i == 14) chk("est locked@15", 32'(locked), 32'd0);
        end
        chk("est ref_level", 32'(ref_level), 32'd65535);
        chk("est locked", 32'(locked), 32'd1);
        sym4(65535, 0, 2'b11, "est new R at R");
        sym4(65534, 0, 2'b10, "est new R below");

        // Saturation of the most negative code.
        do_reset();
        for (int i = 0; i < 16; i++)
            sym4(-131072, 0, 2'b00, $sformatf("sat sym%0d", i));
        chk("sat ref_level", 32'(ref_level), 32'd131071);
        chk("sat locked", 32'(locked), 32'd1);

        // Partial block, then asynchronous reset while sym_valid is high.
        for (int i = 0; i < 5; i++)
            sym4(98303, 0, 2'b10, $sformatf("pre-rst sym%0d", i));
        @(negedge sys_clk);
        sam = 1'b1; sym = 1'b1; y = W'(98303);
        @(negedge sys_clk);
        sam = 1'b0; sym = 1'b0;
        @(posedge sys_clk);
        #2;
        chk("pre-rst valid", 32'(sym_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("async sym_out", 32'(sym_out), 32'd0);
        chk("async sym_valid", 32'(sym_valid), 32'd0);
        chk("async ref_level", 32'(ref_level), 32'd65536);
        chk("async locked", 32'(locked), 32'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            chk("post-rst idle valid", 32'(sym_valid), 32'd0);
        end

        // Counter restarted: the block completes only after 16 fresh symbols.
        for (int i = 0; i < 16; i++) begin
            sym4(98303, 0, 2'b11, $sformatf("post-rst sym%0d", i));
            if (i == 14) chk("post-rst locked@15", 32'(locked), 32'd0);
        end
        chk("post-rst ref_level", 32'(ref_level), 32'd98303);
        chk("post-rst locked", 32'(locked), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ask4_symbol_slicer.md
# ask4_symbol_slicer

Receive-side counterpart of the 4-ASK pulse-shaping transmit filter. Runs after the matched filter in the `sys_clk` domain, gated by the same `sam_clk_en`/`sym_clk_en` strobes from `clk_en`. Each symbol it picks one filtered sample at a selectable phase and slices it against adaptive thresholds to a 2-bit symbol decision. It also outputs a running mean-magnitude reference level and a lock flag.

## Interface
- `WIDTH`, 18, sample width (signed).
- `AVG_LOG2`, 10, log2 of the number of symbols per reference-estimation block.
- `REF_INIT`, 65536, `ref_level` value from reset until the first block completes.
- `sys_clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `sam_clk_en`  in  1  sample strobe, one `sys_clk` cycle wide.
- `sym_clk_en`  in  1  symbol strobe; only meaningful when coincident with `sam_clk_en`.
- `y_in`  in  WIDTH  signed matched-filter output, valid on `sam_clk_en` cycles.
- `phase_sel`  in  2  sample phase (0-3) within the symbol used for the decision.
- `sym_out`  out  2  decision: 00=-3, 01=-1, 10=+1, 11=+3.
- `sym_valid`  out  1  one-cycle pulse when `sym_out` is updated.
- `ref_level`  out  WIDTH  unsigned-magnitude threshold estimate (MSB always 0).
- `locked`  out  1  high once the first estimation block has completed.

## Operation
- **Phase tracking**
  - Phase index is 0 on any cycle with `sam_clk_en & sym_clk_en`.
  - Otherwise the phase index is the previous value + 1 on each `sam_clk_en`, wrapping 3 -> 0.
  - `phase_sel` is latched into `ph_sel_q` only on `sam_clk_en & sym_clk_en`, so a change mid-symbol takes effect at the next symbol.
- **Capture**
  - On a `sam_clk_en` cycle whose phase index equals `ph_sel_q`, register `samp_q <= y_in` and set `cap_q = 1`.
  - `cap_q` is a one-cycle flag.
  - A `sym_clk_en` cycle without `sam_clk_en` is ignored.
- **Magnitude**
  - |`samp_q`| is computed in WIDTH bits.
  - -2^(WIDTH-1) saturates to 2^(WIDTH-1)-1.
- **Slicer** (evaluated on the cycle `cap_q`=1, with R = current `ref_level`)
  - y < -R -> 00
  - -R <= y < 0 -> 01
  - 0 <= y < R -> 10
  - y >= R -> 11
  - Exact-boundary values therefore map upward: -R -> 01, 0 -> 10, R -> 11.
- **Reference estimator**
  - Accumulator is WIDTH+AVG_LOG2 bits unsigned; symbol counter is AVG_LOG2 bits.
  - On each `cap_q`, add |`samp_q`| to the accumulator and increment the counter.
  - When the counter wraps (2^AVG_LOG2 symbols): `ref_level <= (acc + |samp_q|) >> AVG_LOG2`, the accumulator clears to 0, and `locked <= 1`.
  - `locked` stays 1 until reset.
  - The slice on the wrap cycle uses the old `ref_level`.
- **Reset values**
  - `sym_out`=00, `sym_valid`=0, `ref_level`=REF_INIT, `locked`=0.
  - Accumulator, counter, phase index, `ph_sel_q`, `samp_q` and `cap_q` all 0.
- **Reset mid-operation:** everything returns to reset values immediately, the partial block is discarded, and estimation restarts from count 0 after release.

## Timing
- Edge E (capture condition true): `samp_q` loads.
- Edge E+1: `sym_out`, `sym_valid`=1, and any `ref_level`/`locked` update take effect.
- Edge E+2: `sym_valid` returns to 0.
- Latency from capture strobe to decision is 2 `sys_clk` edges.
- `sym_valid` is exactly one cycle wide and occurs once per symbol, provided `sam_clk_en` spacing is at least 3 cycles.
- The first decision after reset release requires a `sym_clk_en` to establish phase 0; samples before it are captured only if the free-running phase index matches `ph_sel_q` (0).
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold `reset`=0 mid-stream -> `sym_out`=00, `sym_valid`=0, `ref_level`=65536, `locked`=0 asynchronously; on release, no `sym_valid` before the next capture.
- **Constant level:** `y_in`=98303 constant, `phase_sel`=0 -> `sym_valid` once per symbol, 2 edges after each `sym_clk_en` sample; `sym_out`=11 every time.
- **Phase select:** `phase_sel`=2, `y_in`=-40000 at phase 2 and +90000 at other phases -> `sym_out`=01 every symbol.
  - Change `phase_sel` to 1 mid-symbol -> the current symbol still uses phase 2; the new phase applies from the next `sym_clk_en`.
- **Estimator (AVG_LOG2=4):** 16 symbols cycling 32768, -32768, 98303, -98303.
  - After the 16th `sym_valid`: `ref_level`=65535, `locked`=1.
  - Decisions in that block use the 65536 threshold: 32768 -> 10, -98303 -> 00.
- **Boundaries (`ref_level`=65536):** `y_in` = -65536 -> 01; 0 -> 10; 65536 -> 11; -65537 -> 00.
- **Saturation:** `y_in`=-131072 for a full block (AVG_LOG2=4) -> `sym_out`=00 each symbol; `ref_level`=131071 with no overflow of the accumulator.
